// File: rtl/dir_btn_conditioner_if.sv
// Signals between the direction-button pins, the conditioner and the cursor-position stage.
interface dir_btn_conditioner_if;
  logic [3:0] btn_raw;
  logic       lock;
  logic [3:0] btn_pulse;
  logic [3:0] btn_level;

  modport master (output btn_raw, output lock, input btn_pulse, input btn_level);
  modport slave  (input btn_raw, input lock, output btn_pulse, output btn_level);
endinterface

// File: rtl/dir_btn_conditioner.sv
// Four-button conditioner: 2-FF synchroniser, debounce filter and press/auto-repeat FSM per
// button, arbitrated into single-cycle move strobes (U > D > L > R).
module dir_btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic                  CLOCK,
  input  logic                  rst_n,
  dir_btn_conditioner_if.slave  bus
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [3:0]      r_s1;
  logic [3:0]      r_s2;
  logic [3:0]      r_level;
  logic [3:0]      r_pulse;
  logic [DB_W-1:0] r_db_cnt [4];
  logic [RP_W-1:0] r_rp_cnt [4];
  state_t          r_state  [4];

  logic [3:0]      w_event;
  logic [3:0]      w_grant;

  // Buttons are independent, so each bit is synchronised on its own; the filter sees only s2.
  // NOTE: all sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_level <= '0;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      r_s1 <= bus.btn_raw;
      r_s2 <= r_s1;
      for (int i = 0; i < 4; i++) begin
        if (r_s2[i] == r_level[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_level[i]  <= r_s2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // A low debounced level forces IDLE from any state, which also gives release priority.
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_state[i]  <= IDLE;
        r_rp_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!r_level[i]) begin
          r_state[i]  <= IDLE;
          r_rp_cnt[i] <= '0;
        end else begin
          case (r_state[i])
            IDLE: begin
              r_state[i]  <= DELAY;
              r_rp_cnt[i] <= '0;
            end
            DELAY: begin
              if (r_rp_cnt[i] == DELAY_LAST) begin
                r_state[i]  <= REPEAT;
                r_rp_cnt[i] <= '0;
              end else begin
                r_rp_cnt[i] <= r_rp_cnt[i] + RP_W'(1);
              end
            end
            REPEAT: begin
              if (r_rp_cnt[i] == PERIOD_LAST) r_rp_cnt[i] <= '0;
              else                            r_rp_cnt[i] <= r_rp_cnt[i] + RP_W'(1);
            end
            default: begin
              r_state[i]  <= IDLE;
              r_rp_cnt[i] <= '0;
            end
          endcase
        end
      end
    end
  end

  // NOTE: w_event gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_event = '0;
    for (int i = 0; i < 4; i++) begin
      case (r_state[i])
        IDLE:    w_event[i] = r_level[i];
        DELAY:   w_event[i] = r_level[i] && (r_rp_cnt[i] == DELAY_LAST);
        REPEAT:  w_event[i] = r_level[i] && (r_rp_cnt[i] == PERIOD_LAST);
        default: w_event[i] = 1'b0;
      endcase
    end
  end

  // Isolate the lowest set bit: U wins, losing events are simply dropped.
  assign w_grant = w_event & (~w_event + 4'd1);

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) r_pulse <= '0;
    else        r_pulse <= bus.lock ? 4'b0 : w_grant;
  end

  assign bus.btn_pulse = r_pulse;
  assign bus.btn_level = r_level;

endmodule

// File: tb/tb_dir_btn_conditioner.sv
// Self-checking bench: directed scenarios with literal strobe schedules plus a randomized
// phase, all compared every cycle against a behavioural model of the button rules.
module tb_dir_btn_conditioner;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic CLOCK;
  logic rst_n;

  dir_btn_conditioner_if bus ();

  dir_btn_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .CLOCK (CLOCK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int mark     = 0;

  int         pt_q[$];
  logic [3:0] pv_q[$];
  int         exp_t[$];
  logic [3:0] exp_v[$];

  // Model state: raw samples delayed through the synchroniser, recent synchronised samples,
  // debounced level and how many consecutive edges each level has been seen high.
  logic [3:0] raw_hist[$];
  logic [3:0] s2_hist[$];
  logic [3:0] m_level;
  int         m_k[4];
  logic [3:0] exp_pulse;
  logic [3:0] exp_level;

  int hold_left[4];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic model_step();
    logic [3:0] s2v;
    logic [3:0] ev;
    logic [3:0] np;
    bit         all_diff;
    if (!rst_n) begin
      raw_hist  = '{4'b0, 4'b0};
      s2_hist.delete();
      m_level   = '0;
      for (int i = 0; i < 4; i++) m_k[i] = 0;
      exp_pulse = '0;
      exp_level = '0;
    end else begin
      raw_hist.push_back(bus.btn_raw);
      s2v = raw_hist.pop_front();
      s2_hist.push_back(s2v);
      if (s2_hist.size() > DB) void'(s2_hist.pop_front());
      ev = '0;
      for (int i = 0; i < 4; i++) begin
        if (m_level[i]) m_k[i]++;
        else            m_k[i] = 0;
        ev[i] = m_level[i] && (m_k[i] == 1 || m_k[i] == RD + 1 ||
                               (m_k[i] > RD + 1 && (m_k[i] - RD - 1) % RP == 0));
      end
      np = '0;
      if (!bus.lock) begin
        for (int i = 0; i < 4; i++) begin
          if (ev[i] && np == 4'b0) np[i] = 1'b1;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (s2_hist.size() == DB) begin
          all_diff = 1'b1;
          foreach (s2_hist[j]) if (s2_hist[j][i] == m_level[i]) all_diff = 1'b0;
          if (all_diff) m_level[i] = ~m_level[i];
        end
      end
      exp_pulse = np;
      exp_level = m_level;
    end
  endtask

  initial begin : compare
    forever begin
      @(posedge CLOCK);
      cyc++;
      model_step();
      #1;
      check($sformatf("cycle%0d_pulse_level", cyc), int'({bus.btn_pulse, bus.btn_level}),
            int'({exp_pulse, exp_level}));
      if (bus.btn_pulse != 4'b0) begin
        pt_q.push_back(cyc - mark);
        pv_q.push_back(bus.btn_pulse);
      end
    end
  end

  task automatic start_window();
    mark = cyc;
    pt_q.delete();
    pv_q.delete();
  endtask

  task automatic wait_neg(input int target);
    while (cyc < target) @(negedge CLOCK);
  endtask

  task automatic check_pulses(input string name);
    check({name, "_count"}, pt_q.size(), exp_t.size());
    for (int i = 0; i < pt_q.size() && i < exp_t.size(); i++) begin
      check($sformatf("%s_time%0d", name, i), pt_q[i], exp_t[i]);
      check($sformatf("%s_bits%0d", name, i), int'(pv_q[i]), int'(exp_v[i]));
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n       = 1'b0;
    bus.btn_raw = 4'b0;
    bus.lock    = 1'b0;
    repeat (3) @(negedge CLOCK);
    rst_n = 1'b1;

    // Reset / idle
    start_window();
    wait_neg(mark + 50);
    check("idle_strobes", pt_q.size(), 0);
    check("idle_level", int'(bus.btn_level), 0);

    // Clean tap on L
    start_window();
    bus.btn_raw = 4'b0100;
    wait_neg(mark + 5);
    check("tap_level_e5", int'(bus.btn_level[2]), 0);
    wait_neg(mark + 6);
    check("tap_level_e6", int'(bus.btn_level[2]), 1);
    wait_neg(mark + 12);
    bus.btn_raw = 4'b0;
    wait_neg(mark + 40);
    exp_t = '{7};
    exp_v = '{4'b0100};
    check_pulses("tap");

    // Bounce on U, then a hold released just before the first repeat would fire
    start_window();
    for (int c = 0; c < 40; c++) begin
      bus.btn_raw[0] = ((c / 2) % 2 == 0);
      @(negedge CLOCK);
    end
    check("bounce_quiet", pt_q.size(), 0);
    bus.btn_raw[0] = 1'b1;
    wait_neg(mark + 60);
    bus.btn_raw[0] = 1'b0;
    wait_neg(mark + 90);
    exp_t = '{47};
    exp_v = '{4'b0001};
    check_pulses("bounce");

    // Auto-repeat on R
    start_window();
    bus.btn_raw = 4'b1000;
    wait_neg(mark + 80);
    bus.btn_raw = 4'b0;
    wait_neg(mark + 110);
    exp_t = '{7, 27, 35, 43, 51, 59, 67, 75, 83};
    exp_v = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
    check_pulses("repeat");

    // Simultaneous U+D, then U released
    start_window();
    bus.btn_raw = 4'b0011;
    wait_neg(mark + 30);
    bus.btn_raw = 4'b0010;
    wait_neg(mark + 60);
    bus.btn_raw = 4'b0;
    wait_neg(mark + 90);
    exp_t = '{7, 27, 35, 43, 51, 59};
    exp_v = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010};
    check_pulses("simul");

    // Lock during a D hold, then reset mid-hold
    start_window();
    bus.btn_raw = 4'b0010;
    wait_neg(mark + 28);
    bus.lock = 1'b1;
    wait_neg(mark + 40);
    check("lock_level", int'(bus.btn_level[1]), 1);
    wait_neg(mark + 45);
    bus.lock = 1'b0;
    wait_neg(mark + 55);
    exp_t = '{7, 27, 51};
    exp_v = '{4'b0010, 4'b0010, 4'b0010};
    check_pulses("lock");
    rst_n = 1'b0;
    #1;
    check("async_reset_pulse", int'(bus.btn_pulse), 0);
    check("async_reset_level", int'(bus.btn_level), 0);
    wait_neg(mark + 58);
    rst_n = 1'b1;
    start_window();
    wait_neg(mark + 20);
    bus.btn_raw = 4'b0;
    wait_neg(mark + 40);
    exp_t = '{7};
    exp_v = '{4'b0010};
    check_pulses("post_reset");

    // Randomized phase: mixes short bounces with long holds, occasional lock and one reset
    start_window();
    for (int b = 0; b < 4; b++) hold_left[b] = 0;
    for (int c = 0; c < 2500; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (hold_left[b] == 0) begin
          bus.btn_raw[b] = 1'($urandom_range(0, 1));
          hold_left[b]   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                       : int'($urandom_range(1, 6));
        end else begin
          hold_left[b]--;
        end
      end
      if ($urandom_range(0, 99) == 0) bus.lock = ~bus.lock;
      if (c == 1500) rst_n = 1'b0;
      if (c == 1503) rst_n = 1'b1;
      @(negedge CLOCK);
    end
    bus.btn_raw = 4'b0;
    bus.lock    = 1'b0;
    wait_neg(cyc + 40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
